// File: rtl/image_bram_pkg.sv
// image_bram_pkg: shared geometry and write-FSM encoding for the image BRAM controller.
package image_bram_pkg;
   localparam int IMG_DEPTH  = 76800;
   localparam int IMG_ADDR_W = 17;
   localparam int IMG_DATA_W = 8;
   typedef enum logic [1:0] {IDLE, WRITE, DONE} wr_state_e;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter, one-hot combinational grant,
// registered pointer naming the requester favoured on the next contention.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o
);
   logic prio_q;
   assign gnt_o[0] = req_i[0] & (~req_i[1] | ~prio_q);
   assign gnt_o[1] = req_i[1] & (~req_i[0] |  prio_q);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) prio_q <= 1'b0;
      else if (|gnt_o) prio_q <= gnt_o[0];
   end
endmodule

// File: rtl/image_bram_arbiter.sv
// image_bram_arbiter: frame-write sequencer plus round-robin shared read port for the image BRAM.
// Define IMG_RD_LOCK_EN to block read grants while a frame write is in progress.
module image_bram_arbiter
   import image_bram_pkg::*;
#(
   parameter int DEPTH  = IMG_DEPTH,
   parameter int ADDR_W = IMG_ADDR_W,
   parameter int DATA_W = IMG_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_start,
   input  logic              wr_valid,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ready,
   output logic              wr_busy,
   output logic              wr_done,
   input  logic              rd0_req,
   input  logic [ADDR_W-1:0] rd0_addr,
   output logic              rd0_gnt,
   output logic              rd0_valid,
   output logic [DATA_W-1:0] rd0_data,
   input  logic              rd1_req,
   input  logic [ADDR_W-1:0] rd1_addr,
   output logic              rd1_gnt,
   output logic              rd1_valid,
   output logic [DATA_W-1:0] rd1_data,
   output logic [ADDR_W-1:0] bram_addr_write,
   output logic              bram_we,
   output logic [DATA_W-1:0] bram_data_in,
   output logic [ADDR_W-1:0] bram_addr_read,
   input  logic [DATA_W-1:0] bram_data_out
);
   wr_state_e         state_q;
   logic [ADDR_W-1:0] ptr_q, waddr_q, raddr_q, sel_addr, raddr_d;
   logic [DATA_W-1:0] wdata_q, rd0_data_q, rd1_data_q;
   logic              wr_ready_q, wr_busy_q, wr_done_q, we_q;
   logic              pend_q, tag_q, rd0_valid_q, rd1_valid_q, lock, accept;
   logic [1:0]        gnt;

   assign accept = wr_valid & wr_ready_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         waddr_q    <= '0;
         wdata_q    <= '0;
         we_q       <= 1'b0;
         wr_ready_q <= 1'b0;
         wr_busy_q  <= 1'b0;
         wr_done_q  <= 1'b0;
      end else begin
         we_q      <= accept;
         wr_done_q <= 1'b0;
         if (accept) begin
            waddr_q <= ptr_q;
            wdata_q <= wr_data;
            ptr_q   <= ptr_q + 1'b1;
         end
         case (state_q)
            IDLE: if (wr_start) begin
               state_q    <= WRITE;
               ptr_q      <= '0;
               wr_ready_q <= 1'b1;
               wr_busy_q  <= 1'b1;
            end
            WRITE: if (accept && ptr_q == ADDR_W'(DEPTH - 1)) begin
               state_q    <= DONE;
               wr_ready_q <= 1'b0;
               wr_busy_q  <= 1'b0;
               wr_done_q  <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef IMG_RD_LOCK_EN
   assign lock = (state_q == WRITE);
`else
   assign lock = 1'b0;
`endif

   rr_arbiter2 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req_i ({rd1_req, rd0_req} & {2{~lock}}),
      .gnt_o (gnt)
   );

   // Out-of-range addresses read the last pixel rather than wrapping.
   assign sel_addr = gnt[1] ? rd1_addr : rd0_addr;
   assign raddr_d  = (sel_addr >= ADDR_W'(DEPTH)) ? ADDR_W'(DEPTH - 1) : sel_addr;

   // pend_q/tag_q follow the address through the BRAM's negedge read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         raddr_q     <= '0;
         tag_q       <= 1'b0;
         pend_q      <= 1'b0;
         rd0_valid_q <= 1'b0;
         rd1_valid_q <= 1'b0;
         rd0_data_q  <= '0;
         rd1_data_q  <= '0;
      end else begin
         pend_q      <= |gnt;
         rd0_valid_q <= pend_q & ~tag_q;
         rd1_valid_q <= pend_q & tag_q;
         if (|gnt) begin
            raddr_q <= raddr_d;
            tag_q   <= gnt[1];
         end
         if (pend_q & ~tag_q) rd0_data_q <= bram_data_out;
         if (pend_q & tag_q) rd1_data_q <= bram_data_out;
      end
   end

   assign wr_ready        = wr_ready_q;
   assign wr_busy         = wr_busy_q;
   assign wr_done         = wr_done_q;
   assign bram_we         = we_q;
   assign bram_addr_write = waddr_q;
   assign bram_data_in    = wdata_q;
   assign bram_addr_read  = raddr_q;
   assign rd0_gnt         = gnt[0];
   assign rd1_gnt         = gnt[1];
   assign rd0_valid       = rd0_valid_q;
   assign rd1_valid       = rd1_valid_q;
   assign rd0_data        = rd0_data_q;
   assign rd1_data        = rd1_data_q;
endmodule

// File: doc/image_bram_arbiter.md
Name: image_bram_arbiter

Overview:
- Controller for the 76800-byte (320x240, 8-bit) image BRAM, which has one write port, one read port, and updates both on the falling clock edge.
- Sequences full-frame writes from a pixel source. Writes are streamed into addresses 0..76799 through a valid/ready handshake.
- Shares the single read port between two read requesters (display and processing unit) using round-robin arbitration.
- Sits between the capture/processing datapath and the image storage instance.

Parameters:
DEPTH, 76800, number of byte locations in the image BRAM
ADDR_W, 17, address width
DATA_W, 8, pixel width

Ports:
clk  in  1  main clock; all logic on rising edge
rst_n  in  1  asynchronous reset, active-low
wr_start  in  1  start frame write at address 0
wr_valid  in  1  wr_data valid
wr_data  in  DATA_W  pixel byte
wr_ready  out  1  controller accepts a byte this cycle
wr_busy  out  1  frame write in progress
wr_done  out  1  one-cycle pulse after last byte accepted
rd0_req  in  1  requester 0 read request
rd0_addr  in  ADDR_W  requester 0 address
rd0_gnt  out  1  requester 0 request accepted this cycle
rd0_valid  out  1  rd0_data valid (pulse)
rd0_data  out  DATA_W  read data for requester 0
rd1_req, rd1_addr, rd1_gnt, rd1_valid, rd1_data  (same widths and meanings, requester 1)
bram_addr_write  out  ADDR_W  to BRAM write address
bram_we  out  1  to BRAM write enable
bram_data_in  out  DATA_W  to BRAM write data
bram_addr_read  out  ADDR_W  to BRAM read address
bram_data_out  in  DATA_W  from BRAM read data

Behaviour:
- Reset: all outputs 0; write FSM in IDLE; write pointer 0; round-robin pointer favours rd0; read pipeline empty. BRAM contents are untouched.
- Write FSM has three states:
  - IDLE: wr_ready=0, wr_busy=0. wr_start moves to WRITE and clears the pointer.
  - WRITE: wr_ready=1, wr_busy=1. On wr_valid&wr_ready, register bram_we=1, bram_addr_write=ptr and bram_data_in=wr_data, then increment ptr. The byte accepted at ptr=DEPTH-1 moves the FSM to DONE; wr_ready is 0 from the next cycle.
  - DONE: wr_done=1 for one cycle, then IDLE.
- wr_start is ignored in WRITE and DONE.
- bram_we is 0 in every cycle without an accepted byte. Write throughput is 1 byte/cycle.
- Read arbitration (combinational grant):
  - rdX_gnt = rdX_req & selected.
  - One requester only: that requester wins.
  - Both requesting: the requester not granted last wins.
  - The pointer updates only on a grant.
- Requesters hold req and addr stable until gnt.
- Read pipeline:
  - Grant cycle N: the winning address is registered into bram_addr_read, clamped to DEPTH-1 if ≥ DEPTH, and the winner's ID is registered.
  - BRAM updates data_out on the negedge in cycle N+1.
  - At the end of N+1, data_out is captured into rdX_data. rdX_valid is high in cycle N+2 for the tagged requester only.
- rdX_data holds its value between valid pulses.
- Back-to-back grants are sustained at 1/cycle.
- Same-address read and write on the same negedge: the read returns the pre-write byte. No bypass.
- Reset mid-frame: the FSM returns to IDLE and in-flight read valids are dropped. The frame must be restarted with wr_start.

Optional Feature:
- Macro: IMG_RD_LOCK_EN.
- Defined: no read grants while the FSM is in WRITE (tear-free frames). Requests stall with gnt=0. Reads already in flight complete normally. Grants resume in the DONE cycle.
- Undefined: reads are granted at any time, independent of writes.

Decomposition:
- Package image_bram_pkg holds: IMG_DEPTH=76800, IMG_ADDR_W=17, IMG_DATA_W=8, and the write FSM state encoding (IDLE, WRITE, DONE).
- One sub-module: rr_arbiter2, a two-way round-robin with a registered last-grant pointer and a one-hot grant output.

Test Plan:
- Reset, then wr_start and 76800 continuous wr_valid bytes (data=addr[7:0]). Expect bram_we on every cycle, addresses 0..76799, wr_done pulse exactly one cycle after the last accept, and wr_ready=0 afterwards.
- Gapped write (wr_valid toggling every other cycle). Expect bram_we only on accept cycles, no pointer skips, and wr_start mid-frame ignored.
- rd0_req alone, addr=100, BRAM preloaded with 0x5A at 100. Expect gnt in cycle N, bram_addr_read=100 in N+1, and rd0_valid with rd0_data=0x5A in N+2.
- rd0 and rd1 requesting continuously. Expect alternating grants starting with rd0, one valid per cycle, and the valid tag matching the granted requester.
- rd1_addr=80000. Expect bram_addr_read=76799 with data from that location. Simultaneous read and write at addr 5 (old 0x11, new 0x22) → read returns 0x11.
- With IMG_RD_LOCK_EN: rd0_req held during WRITE → gnt=0 until the DONE cycle. Assert rst_n low mid-frame → all outputs 0 and FSM in IDLE.
